// File: rtl/tdc_mux_pkg.sv
// rtl/tdc_mux_pkg.sv - mode constants and FSM encoding for the TDC channel selector
package tdc_mux_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   typedef enum logic {
      ST_MANUAL = 1'b0,
      ST_SCAN   = 1'b1
   } mux_state_e;

endpackage

// File: rtl/tdc_scan_ptr.sv
// rtl/tdc_scan_ptr.sv - scan pointer with per-channel dwell counter and wrap
module tdc_scan_ptr #(
   parameter int NCH   = 4,
   parameter int DWELL = 4,
   parameter int SELW  = $clog2(NCH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            adv_now,
   input  logic            load0,
   output logic [SELW-1:0] scan_ch
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

   logic [CW-1:0] cnt;
   logic          dwell_done;
   logic          at_last;

   assign dwell_done = (32'(cnt) == 32'(DWELL - 1));
   assign at_last    = (32'(scan_ch) == 32'(NCH - 1));

   // A capture ends the dwell early so each visit yields at most one word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_ch <= '0;
         cnt     <= '0;
      end else if (load0) begin
         scan_ch <= '0;
         cnt     <= '0;
      end else if (en) begin
         if (adv_now || dwell_done) begin
            scan_ch <= at_last ? '0 : scan_ch + 1'b1;
            cnt     <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tdc_chan_mux.sv
// rtl/tdc_chan_mux.sv - registered N-channel selector with manual and scan modes
module tdc_chan_mux
   import tdc_mux_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int W     = 8,
   parameter int SELW  = $clog2(NCH),
   parameter int DWELL = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH*W-1:0] din,
   input  logic [NCH-1:0]   ch_valid,
   input  logic             mode,
   input  logic [SELW-1:0]  sel,
   output logic [W-1:0]     out_data,
   output logic [SELW-1:0]  out_ch,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SELW-1:0]  scan_ch,
   output logic             sel_err,
   output logic             ovf
);

   mux_state_e state_q, state_d;

   logic [SELW-1:0] ach;
   logic [W-1:0]    data_sel;
   logic            vld_sel;
   logic            ach_hit;
   logic            slot_free;
   logic            stall;
   logic            capture;
   logic            load0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_MANUAL;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = ST_MANUAL;
      if (mode == MODE_SCAN) state_d = ST_SCAN;
   end

   // The active channel follows the registered state, so the MANUAL->SCAN edge
   // still selects via sel and never captures from the freshly loaded pointer.
   always_comb begin
      ach      = (state_q == ST_SCAN) ? scan_ch : sel;
      data_sel = '0;
      vld_sel  = 1'b0;
      ach_hit  = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (ach == SELW'(k)) begin
            data_sel = din[k*W +: W];
            vld_sel  = ch_valid[k];
            ach_hit  = 1'b1;
         end
      end
   end

   assign slot_free = !out_valid || out_ready;
   assign stall     = out_valid && !out_ready;
   assign capture   = slot_free && ach_hit && vld_sel;
   assign load0     = (state_q != ST_SCAN) || (state_d != ST_SCAN);

   tdc_scan_ptr #(
      .NCH   (NCH),
      .DWELL (DWELL),
      .SELW  (SELW)
   ) u_scan_ptr (
      .clk     (clk),
      .rst     (rst),
      .en      (slot_free),
      .adv_now (capture),
      .load0   (load0),
      .scan_ch (scan_ch)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
      end else if (capture) begin
         out_data  <= data_sel;
         out_ch    <= ach;
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_err <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         sel_err <= (state_q == ST_MANUAL) && (32'(sel) >= 32'(NCH));
         if (stall && ach_hit && vld_sel) ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tdc_chan_mux.sv
// tb/tb_tdc_chan_mux.sv - directed self-checking bench for tdc_chan_mux
module tb_tdc_chan_mux;

   logic        clk;
   logic        rst;

   logic [31:0] din4;
   logic [3:0]  cv4;
   logic        mode4;
   logic [1:0]  sel4;
   logic        rdy4;
   logic [7:0]  data4;
   logic [1:0]  och4;
   logic        val4;
   logic [1:0]  scan4;
   logic        serr4;
   logic        ovf4;

   logic [23:0] din3;
   logic [2:0]  cv3;
   logic        mode3;
   logic [1:0]  sel3;
   logic        rdy3;
   logic [7:0]  data3;
   logic [1:0]  och3;
   logic        val3;
   logic [1:0]  scan3;
   logic        serr3;
   logic        ovf3;

   int checks = 0;
   int errors = 0;

   int exp_scan_cap [20] = '{0,0,0,0,1,2,2,2,2,3,3,3,3,0,0,0,0,1,2,2};

   tdc_chan_mux #(.NCH(4), .W(8), .DWELL(4)) dut4 (
      .clk(clk), .rst(rst), .din(din4), .ch_valid(cv4), .mode(mode4), .sel(sel4),
      .out_data(data4), .out_ch(och4), .out_valid(val4), .out_ready(rdy4),
      .scan_ch(scan4), .sel_err(serr4), .ovf(ovf4)
   );

   tdc_chan_mux #(.NCH(3), .W(8), .DWELL(4)) dut3 (
      .clk(clk), .rst(rst), .din(din3), .ch_valid(cv3), .mode(mode3), .sel(sel3),
      .out_data(data3), .out_ch(och3), .out_valid(val3), .out_ready(rdy3),
      .scan_ch(scan3), .sel_err(serr3), .ovf(ovf3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      din4 = '0; cv4 = '0; mode4 = 1'b0; sel4 = '0; rdy4 = 1'b1;
      din3 = '0; cv3 = '0; mode3 = 1'b0; sel3 = '0; rdy3 = 1'b1;
      tick();
      tick();
      checks++;
      if ({val4, data4, och4, scan4, serr4, ovf4} !== 15'd0) begin
         errors++;
         $display("FAIL reset_state: got val=%0b data=%h ch=%0d scan=%0d serr=%0b ovf=%0b, want all 0",
                  val4, data4, och4, scan4, serr4, ovf4);
      end
      rst = 1'b0;
   endtask

   task automatic test_manual();
      sel4 = 2'd2; din4 = 32'h00A5_0000; cv4 = 4'b0100; rdy4 = 1'b1;
      tick();
      checks++;
      if ({val4, data4, och4} !== {1'b1, 8'hA5, 2'd2}) begin
         errors++;
         $display("FAIL manual_capture: got val=%0b data=%h ch=%0d, want 1 a5 2", val4, data4, och4);
      end
      cv4 = 4'b0000;
      tick();
      checks++;
      if (val4 !== 1'b0) begin
         errors++;
         $display("FAIL manual_drain: got val=%0b, want 0", val4);
      end
   endtask

   task automatic test_stall();
      din4 = 32'h00A5_0000; cv4 = 4'b0100; rdy4 = 1'b0;
      tick();
      din4 = 32'h003C_0000;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({val4, data4, och4} !== {1'b1, 8'hA5, 2'd2}) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got val=%0b data=%h ch=%0d, want 1 a5 2", i, val4, data4, och4);
         end
      end
      checks++;
      if (ovf4 !== 1'b1) begin
         errors++;
         $display("FAIL stall_ovf: got %0b, want 1", ovf4);
      end
      rdy4 = 1'b1;
      tick();
      checks++;
      if ({val4, data4} !== {1'b1, 8'h3C}) begin
         errors++;
         $display("FAIL stall_release: got val=%0b data=%h, want 1 3c", val4, data4);
      end
      cv4 = 4'b0000;
      tick();
      checks++;
      if ({val4, ovf4} !== 2'b01) begin
         errors++;
         $display("FAIL ovf_sticky: got val=%0b ovf=%0b, want val=0 ovf=1", val4, ovf4);
      end
   endtask

   task automatic test_scan_idle();
      cv4 = 4'b0000; rdy4 = 1'b1; mode4 = 1'b1;
      for (int i = 0; i < 17; i++) begin
         tick();
         checks++;
         if ({val4, scan4} !== {1'b0, 2'((i / 4) % 4)}) begin
            errors++;
            $display("FAIL scan_idle[%0d]: got val=%0b scan=%0d, want val=0 scan=%0d",
                     i, val4, scan4, (i / 4) % 4);
         end
      end
   endtask

   task automatic test_scan_capture();
      int words;
      mode4 = 1'b0; sel4 = 2'd0;
      tick();
      din4 = 32'h0000_1100; cv4 = 4'b0010; mode4 = 1'b1; rdy4 = 1'b1;
      words = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (scan4 !== 2'(exp_scan_cap[i]) || val4 !== (i == 5 || i == 18)) begin
            errors++;
            $display("FAIL scan_capture[%0d]: got scan=%0d val=%0b, want scan=%0d val=%0b",
                     i, scan4, val4, exp_scan_cap[i], (i == 5 || i == 18));
         end
         if (val4) begin
            words++;
            checks++;
            if ({data4, och4} !== {8'h11, 2'd1}) begin
               errors++;
               $display("FAIL scan_word[%0d]: got data=%h ch=%0d, want 11 1", i, data4, och4);
            end
         end
      end
      checks++;
      if (words !== 2) begin
         errors++;
         $display("FAIL scan_word_count: got %0d, want 2", words);
      end
   endtask

   task automatic test_scan_stall();
      cv4 = 4'b1111; rdy4 = 1'b0; din4 = 32'h4433_2211;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({val4, data4, och4, scan4} !== {1'b1, 8'h33, 2'd2, 2'd3}) begin
            errors++;
            $display("FAIL scan_stall[%0d]: got val=%0b data=%h ch=%0d scan=%0d, want 1 33 2 3",
                     i, val4, data4, och4, scan4);
         end
      end
      cv4 = 4'b0000; rdy4 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (scan4 !== ((i == 3) ? 2'd0 : 2'd3)) begin
            errors++;
            $display("FAIL scan_resume[%0d]: got scan=%0d, want %0d", i, scan4, (i == 3) ? 0 : 3);
         end
      end
      cv4 = 4'b1111; rdy4 = 1'b0;
      tick();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({val4, data4, och4, scan4, serr4, ovf4} !== 15'd0) begin
         errors++;
         $display("FAIL async_reset: got val=%0b data=%h ch=%0d scan=%0d serr=%0b ovf=%0b, want all 0",
                  val4, data4, och4, scan4, serr4, ovf4);
      end
      tick();
      rst = 1'b0; mode4 = 1'b0; cv4 = 4'b0000; rdy4 = 1'b1;
   endtask

   task automatic test_sel_err();
      din3 = 24'h33_2211; cv3 = 3'b111; sel3 = 2'd3; rdy3 = 1'b1; mode3 = 1'b0;
      tick();
      checks++;
      if ({serr3, val3} !== 2'b10) begin
         errors++;
         $display("FAIL sel_err_pulse: got serr=%0b val=%0b, want 1 0", serr3, val3);
      end
      sel3 = 2'd1;
      tick();
      checks++;
      if ({serr3, val3, data3, och3} !== {1'b0, 1'b1, 8'h22, 2'd1}) begin
         errors++;
         $display("FAIL sel_err_clear: got serr=%0b val=%0b data=%h ch=%0d, want 0 1 22 1",
                  serr3, val3, data3, och3);
      end
   endtask

   initial begin
      test_reset();
      test_manual();
      test_stall();
      test_scan_idle();
      test_scan_capture();
      test_scan_stall();
      test_sel_err();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
